// File: rtl/sw_in_buf_1ton_if.sv
// sw_in_buf_1ton_if: upstream and downstream handshake bundle of the switch input buffer.
interface sw_in_buf_1ton_if #(parameter int OUT_N = 4, parameter int TAG_W = 4);
  logic             upreq_i;
  logic [TAG_W-1:0] uptag_i;
  logic             uprdy_o;
  logic [OUT_N-1:0] dnreq_o;
  logic [TAG_W-1:0] dntag_o;
  logic [OUT_N-1:0] dnrdy_i;
  modport slave(input upreq_i, uptag_i, dnrdy_i, output uprdy_o, dnreq_o, dntag_o);
  modport master(output upreq_i, uptag_i, dnrdy_i, input uprdy_o, dnreq_o, dntag_o);
endinterface

// File: rtl/sw_in_buf_1ton.sv
// sw_in_buf_1ton: FIFO input stage steering head flits to one of OUT_N outputs, dropping illegal dests.
// Defining SW_IN_BUF_BYPASS_EN lets a legal flit skip an empty FIFO in the same cycle.
module sw_in_buf_1ton #(
  parameter int OUT_N = 4,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  sw_in_buf_1ton_if.slave          s,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);
  localparam int DST_W = $clog2(OUT_N);
  localparam int AW    = $clog2(DEPTH);
  localparam int PN    = 1 << DST_W;
  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_occ;
  logic [CNT_W-1:0] r_drop;
  logic [TAG_W-1:0] w_head;
  logic [DST_W-1:0] w_hd, w_id, w_sd;
  logic [PN-1:0]    w_rdy, w_oh;
  logic             w_hv, w_hlegal, w_bp, w_sv, w_push, w_pop, w_drop, w_wr;
`ifdef SW_IN_BUF_BYPASS_EN
  logic             w_ilegal;
`endif
  always_comb begin
    w_head      = r_mem[r_rptr];
    w_hd        = w_head[DST_W-1:0];
    w_id        = s.uptag_i[DST_W-1:0];
    w_hv        = r_occ != '0;
    w_hlegal    = 32'(w_hd) < OUT_N;
    w_rdy       = PN'(s.dnrdy_i);
    s.uprdy_o   = !rst && r_occ != (AW+1)'(DEPTH);
    w_push      = s.upreq_i & s.uprdy_o;
`ifdef SW_IN_BUF_BYPASS_EN
    w_ilegal    = 32'(w_id) < OUT_N;
    w_bp        = !w_hv & w_push & w_ilegal;
`else
    w_bp        = 1'b0;
`endif
    w_sd        = w_bp ? w_id : w_hd;
    w_sv        = w_bp | (w_hv & w_hlegal);
    w_oh        = PN'(1) << w_sd;
    s.dnreq_o   = w_sv ? w_oh[OUT_N-1:0] : '0;
    s.dntag_o   = w_bp ? s.uptag_i : w_head;
    w_drop      = w_hv & !w_hlegal;
    w_pop       = w_drop | (w_hv & w_hlegal & w_rdy[w_hd]);
    // a bypassed flit that is accepted downstream never enters the FIFO
    w_wr        = w_push & !(w_bp & w_rdy[w_id]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      r_drop <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr != w_pop) r_occ <= w_wr ? r_occ + 1'b1 : r_occ - 1'b1;
      if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= s.uptag_i;
  end
  assign occ_o      = r_occ;
  assign drop_cnt_o = r_drop;
endmodule

// File: tb/tb_sw_in_buf_1ton.sv
// tb_sw_in_buf_1ton: drives an OUT_N=4 and an OUT_N=3/CNT_W=2 instance in lockstep against a queue model.
module tb_sw_in_buf_1ton;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0;
  logic [3:0] tag = '0;
  logic [3:0] rdy = '0;
  logic [2:0] occ0, occ1;
  logic [7:0] drop0;
  logic [1:0] drop1;
  int total = 0;
  int bad = 0;
  int q[2][$];
  int dc[2] = '{0, 0};
  always #5 clk = ~clk;
  sw_in_buf_1ton_if #(.OUT_N(4), .TAG_W(4)) b0();
  sw_in_buf_1ton_if #(.OUT_N(3), .TAG_W(4)) b1();
  assign b0.upreq_i = up;
  assign b0.uptag_i = tag;
  assign b0.dnrdy_i = rdy;
  assign b1.upreq_i = up;
  assign b1.uptag_i = tag;
  assign b1.dnrdy_i = rdy[2:0];
  sw_in_buf_1ton #(.OUT_N(4), .TAG_W(4), .DEPTH(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .s(b0.slave), .occ_o(occ0), .drop_cnt_o(drop0));
  sw_in_buf_1ton #(.OUT_N(3), .TAG_W(4), .DEPTH(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .s(b1.slave), .occ_o(occ1), .drop_cnt_o(drop1));
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", t, got, exp, $time);
    end
  endtask
  task automatic check_reset();
    chk("rst_occ0", 32'(occ0), 0);
    chk("rst_occ1", 32'(occ1), 0);
    chk("rst_req0", 32'(b0.dnreq_o), 0);
    chk("rst_req1", 32'(b1.dnreq_o), 0);
    chk("rst_drop0", 32'(drop0), 0);
    chk("rst_drop1", 32'(drop1), 0);
    chk("rst_rdy0", 32'(b0.uprdy_o), 0);
    chk("rst_rdy1", 32'(b1.uprdy_o), 0);
  endtask
  // one cycle: drive at negedge, compare against the model, then commit the model at posedge
  task automatic step(input logic u, input logic [3:0] tg, input logic [3:0] r);
    bit pop[2];
    bit push[2];
    @(negedge clk);
    up = u;
    tag = tg;
    rdy = r;
    #1;
    for (int k = 0; k < 2; k++) begin
      int nn = k ? 3 : 4;
      int sz = q[k].size();
      int er = 0;
      int et = 0;
      int d = 0;
      bit bp = 0;
      logic [31:0] greq = k ? 32'(b1.dnreq_o) : 32'(b0.dnreq_o);
      logic [31:0] gtag = k ? 32'(b1.dntag_o) : 32'(b0.dntag_o);
      logic [31:0] grdy = k ? 32'(b1.uprdy_o) : 32'(b0.uprdy_o);
      logic [31:0] gocc = k ? 32'(occ1) : 32'(occ0);
      logic [31:0] gdrp = k ? 32'(drop1) : 32'(drop0);
      if (sz > 0) begin
        d = q[k][0] % 4;
        if (d < nn) begin
          er = 1 << d;
          et = q[k][0];
        end
      end
`ifdef SW_IN_BUF_BYPASS_EN
      if (sz == 0 && u && int'(tg) % 4 < nn) begin
        bp = 1;
        er = 1 << (int'(tg) % 4);
        et = int'(tg);
      end
`endif
      chk($sformatf("req%0d", k), greq, er);
      if (er != 0) chk($sformatf("tag%0d", k), gtag, et);
      chk($sformatf("uprdy%0d", k), grdy, (sz != 4) ? 1 : 0);
      chk($sformatf("occ%0d", k), gocc, sz);
      chk($sformatf("drop%0d", k), gdrp, dc[k]);
      pop[k] = sz > 0 && (d >= nn || r[d]);
      push[k] = u && sz != 4 && !(bp && r[int'(tg) % 4]);
      if (pop[k] && d >= nn && dc[k] < (k ? 3 : 255)) dc[k]++;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (pop[k]) void'(q[k].pop_front());
      if (push[k]) q[k].push_back(int'(tg));
    end
  endtask
  initial begin
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(0, 4'h0, 4'hF);
    step(1, 4'h1, 4'hF);
    step(1, 4'h6, 4'hF);
    step(1, 4'hB, 4'hF);
    repeat (3) step(0, 4'h0, 4'hF);
    repeat (5) step(1, 4'h4, 4'h0);
    repeat (3) step(1, 4'h8, 4'h0);
    repeat (6) step(1, 4'hC, 4'h1);
    repeat (4) step(0, 4'h0, 4'hF);
    step(1, 4'h2, 4'hF);
    step(1, 4'h5, 4'h0);
    repeat (10) step(1, 4'(($urandom % 4) * 4 + 1), 4'h2);
    repeat (4) step(0, 4'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step(1, 4'h3, 4'hF);
      step(1, 4'h7, 4'h0);
    end
    repeat (4) step(0, 4'h0, 4'hF);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom), (i % 500 < 250) ? 4'($urandom) : 4'hF);
    repeat (6) step(0, 4'h0, 4'hF);
    repeat (3) step(1, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    up = 1'b1;
    #1;
    check_reset();
    q[0].delete();
    q[1].delete();
    dc = '{0, 0};
    @(negedge clk);
    rst = 1'b0;
    up = 1'b0;
    step(0, 4'h0, 4'hF);
    repeat (200) step($urandom_range(0, 1) != 0, 4'($urandom), 4'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
